// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the 16-bit core.
// Captures the ALU result, store data and control bits, and resolves
// conditional branches into a one-cycle registered redirect.
// After a taken branch, a fixed number of younger accepted instructions
// is dropped. A latched HALT freezes the stage until reset.
module ex_mem_stage #(
    parameter int SHADOW_DEPTH = 2,
    parameter int WIDTH        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    input  logic             flush,
    input  logic [4:0]       ex_opcode,
    input  logic [1:0]       ex_funct,
    input  logic [WIDTH-1:0] aluout,
    input  logic             equalto,
    input  logic             lt,
    input  logic             gt,
    input  logic [WIDTH-1:0] ex_pc_plus2,
    input  logic [WIDTH-1:0] ex_br_offset,
    input  logic [WIDTH-1:0] ex_store_data,
    input  logic [2:0]       ex_wr_reg,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic             ex_halt,
    output logic             mem_valid,
    output logic [WIDTH-1:0] mem_aluout,
    output logic [WIDTH-1:0] mem_store_data,
    output logic [2:0]       mem_wr_reg,
    output logic             mem_reg_write,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic [1:0]       ex_funct_q,
    output logic             mem_halt,
    output logic             br_redirect,
    output logic [WIDTH-1:0] br_target
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SHADOW = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] shadow_cnt;
    logic       accept;
    logic       taken;

    // The stage refuses new work while the downstream is stalled or after a halt.
    assign in_ready = ~stall & (state != HALTED);
    assign accept   = in_valid & in_ready & ~flush;

    // Branch condition decode for the 011xx conditional branch group.
    always_comb begin
        taken = 1'b0;
        if (ex_opcode[4:2] == 3'b011) begin
            case (ex_opcode[1:0])
                2'b00:   taken = equalto;
                2'b01:   taken = ~equalto;
                2'b10:   taken = lt;
                2'b11:   taken = gt;
                default: taken = 1'b0;
            endcase
        end else begin
            taken = 1'b0;
        end
    end

    // Pipeline register, branch redirect and run/shadow/halt control.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            shadow_cnt     <= 3'd0;
            mem_valid      <= 1'b0;
            mem_aluout     <= '0;
            mem_store_data <= '0;
            mem_wr_reg     <= 3'd0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            ex_funct_q     <= 2'd0;
            mem_halt       <= 1'b0;
            br_redirect    <= 1'b0;
            br_target      <= '0;
        end else if (flush) begin
            // Squash contents; a halt stays latched.
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
            br_redirect   <= 1'b0;
            shadow_cnt    <= 3'd0;
            if (state == SHADOW) begin
                state <= RUN;
            end else begin
                state <= state;
            end
        end else if (stall) begin
            // Everything holds except the redirect pulse, which must not stretch.
            br_redirect <= 1'b0;
        end else begin
            br_redirect <= 1'b0;
            if (accept) begin
                case (state)
                    RUN: begin
                        mem_valid      <= 1'b1;
                        mem_aluout     <= aluout;
                        mem_store_data <= ex_store_data;
                        mem_wr_reg     <= ex_wr_reg;
                        mem_reg_write  <= ex_reg_write;
                        mem_mem_read   <= ex_mem_read;
                        mem_mem_write  <= ex_mem_write;
                        ex_funct_q     <= ex_funct;
                        if (taken) begin
                            br_redirect <= 1'b1;
                            br_target   <= ex_pc_plus2 + ex_br_offset;
                        end else begin
                            br_redirect <= 1'b0;
                        end
                        // Halt dominates the shadow when both arrive together.
                        if (ex_halt) begin
                            state    <= HALTED;
                            mem_halt <= 1'b1;
                        end else if (taken) begin
                            state      <= SHADOW;
                            shadow_cnt <= 3'(SHADOW_DEPTH);
                        end else begin
                            state <= RUN;
                        end
                    end
                    SHADOW: begin
                        // Wrong-path instruction: drop it, no redirect, no halt.
                        mem_valid     <= 1'b0;
                        mem_reg_write <= 1'b0;
                        mem_mem_read  <= 1'b0;
                        mem_mem_write <= 1'b0;
                        shadow_cnt    <= shadow_cnt - 3'd1;
                        if (shadow_cnt == 3'd1) begin
                            state <= RUN;
                        end else begin
                            state <= SHADOW;
                        end
                    end
                    default: begin
                        mem_valid     <= 1'b0;
                        mem_reg_write <= 1'b0;
                        mem_mem_read  <= 1'b0;
                        mem_mem_write <= 1'b0;
                    end
                endcase
            end else begin
                mem_valid     <= 1'b0;
                mem_reg_write <= 1'b0;
                mem_mem_read  <= 1'b0;
                mem_mem_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed-vector bench for ex_mem_stage with hand-computed expectations.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, stall, flush;
    logic [4:0]  ex_opcode;
    logic [1:0]  ex_funct;
    logic [15:0] aluout, ex_pc_plus2, ex_br_offset, ex_store_data;
    logic        equalto, lt, gt;
    logic [2:0]  ex_wr_reg;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_halt;
    logic        mem_valid;
    logic [15:0] mem_aluout, mem_store_data;
    logic [2:0]  mem_wr_reg;
    logic        mem_reg_write, mem_mem_read, mem_mem_write;
    logic [1:0]  ex_funct_q;
    logic        mem_halt, br_redirect;
    logic [15:0] br_target;

    int checks = 0;
    int errors = 0;

    ex_mem_stage #(.SHADOW_DEPTH(2), .WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .aluout(aluout), .equalto(equalto), .lt(lt), .gt(gt),
        .ex_pc_plus2(ex_pc_plus2), .ex_br_offset(ex_br_offset),
        .ex_store_data(ex_store_data), .ex_wr_reg(ex_wr_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_halt(ex_halt),
        .mem_valid(mem_valid), .mem_aluout(mem_aluout),
        .mem_store_data(mem_store_data), .mem_wr_reg(mem_wr_reg),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .ex_funct_q(ex_funct_q),
        .mem_halt(mem_halt), .br_redirect(br_redirect), .br_target(br_target)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        ex_opcode = 5'd0; ex_funct = 2'd0; aluout = 16'h0000;
        equalto = 1'b0; lt = 1'b0; gt = 1'b0;
        ex_pc_plus2 = 16'h0000; ex_br_offset = 16'h0000; ex_store_data = 16'h0000;
        ex_wr_reg = 3'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        ex_mem_write = 1'b0; ex_halt = 1'b0;
    endtask

    task automatic add_op(input logic [15:0] val);
        clear_in();
        in_valid = 1'b1; ex_opcode = 5'b00000; aluout = val;
        ex_wr_reg = 3'd3; ex_reg_write = 1'b1;
    endtask

    task automatic br_op(input logic [4:0] op, input logic [15:0] pc2, input logic [15:0] off,
                         input logic eq, input logic l, input logic g);
        clear_in();
        in_valid = 1'b1; ex_opcode = op; ex_pc_plus2 = pc2; ex_br_offset = off;
        equalto = eq; lt = l; gt = g;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check_eq("rst_valid", 32'(mem_valid), 32'd0);
        check_eq("rst_aluout", 32'(mem_aluout), 32'd0);
        check_eq("rst_halt", 32'(mem_halt), 32'd0);
        check_eq("rst_redir", 32'(br_redirect), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);

        // Plain ADD
        add_op(16'h1234); ex_funct = 2'b10; ex_store_data = 16'h5A5A; ex_mem_write = 1'b1;
        step();
        check_eq("add_valid", 32'(mem_valid), 32'd1);
        check_eq("add_aluout", 32'(mem_aluout), 32'h1234);
        check_eq("add_wr_reg", 32'(mem_wr_reg), 32'd3);
        check_eq("add_rw", 32'(mem_reg_write), 32'd1);
        check_eq("add_funct", 32'(ex_funct_q), 32'd2);
        check_eq("add_sdata", 32'(mem_store_data), 32'h5A5A);
        check_eq("add_mw", 32'(mem_mem_write), 32'd1);
        clear_in();
        step();
        check_eq("idle_valid", 32'(mem_valid), 32'd0);
        check_eq("idle_rw", 32'(mem_reg_write), 32'd0);
        check_eq("idle_mw", 32'(mem_mem_write), 32'd0);

        // BEQZ taken, backward target, then a 2-deep shadow
        br_op(5'b01100, 16'h0010, 16'hFFF8, 1'b1, 1'b0, 1'b0);
        step();
        check_eq("beqz_redir", 32'(br_redirect), 32'd1);
        check_eq("beqz_target", 32'(br_target), 32'h0008);
        check_eq("beqz_valid", 32'(mem_valid), 32'd1);
        add_op(16'h1111);
        step();
        check_eq("sh1_valid", 32'(mem_valid), 32'd0);
        check_eq("sh1_redir", 32'(br_redirect), 32'd0);
        br_op(5'b01100, 16'h0040, 16'h0002, 1'b1, 1'b0, 1'b0);
        step();
        check_eq("sh2_valid", 32'(mem_valid), 32'd0);
        check_eq("sh2_no_redir", 32'(br_redirect), 32'd0);
        add_op(16'h3333);
        step();
        check_eq("post_sh_valid", 32'(mem_valid), 32'd1);
        check_eq("post_sh_aluout", 32'(mem_aluout), 32'h3333);

        // BLTZ not taken, BGEZ taken with wrap
        br_op(5'b01110, 16'h0020, 16'h0010, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("bltz_redir", 32'(br_redirect), 32'd0);
        check_eq("bltz_valid", 32'(mem_valid), 32'd1);
        br_op(5'b01111, 16'hFFFE, 16'h0004, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("bgez_redir", 32'(br_redirect), 32'd1);
        check_eq("bgez_target", 32'(br_target), 32'h0002);

        // Flush inside the shadow cancels it
        clear_in(); flush = 1'b1;
        step();
        check_eq("flush_valid", 32'(mem_valid), 32'd0);
        check_eq("flush_redir", 32'(br_redirect), 32'd0);
        add_op(16'h5555); equalto = 1'b1; lt = 1'b1; gt = 1'b1; ex_opcode = 5'b00101;
        step();
        check_eq("unsh_valid", 32'(mem_valid), 32'd1);
        check_eq("unsh_aluout", 32'(mem_aluout), 32'h5555);
        check_eq("nonbr_redir", 32'(br_redirect), 32'd0);

        // Taken branch followed by a stall
        br_op(5'b01101, 16'h0100, 16'h0020, 1'b0, 1'b0, 1'b0); aluout = 16'hAAAA;
        step();
        check_eq("bnez_redir", 32'(br_redirect), 32'd1);
        check_eq("bnez_target", 32'(br_target), 32'h0120);
        add_op(16'hBBBB); stall = 1'b1;
        #1;
        check_eq("stall_ready", 32'(in_ready), 32'd0);
        step();
        check_eq("stall_redir", 32'(br_redirect), 32'd0);
        check_eq("stall_valid", 32'(mem_valid), 32'd1);
        check_eq("stall_aluout", 32'(mem_aluout), 32'hAAAA);
        step();
        check_eq("stall2_aluout", 32'(mem_aluout), 32'hAAAA);
        clear_in();
        step();
        check_eq("gap_valid", 32'(mem_valid), 32'd0);
        add_op(16'hBBBB);
        step();
        check_eq("sd1_valid", 32'(mem_valid), 32'd0);
        step();
        check_eq("sd2_valid", 32'(mem_valid), 32'd0);
        step();
        check_eq("sd3_valid", 32'(mem_valid), 32'd1);
        check_eq("sd3_aluout", 32'(mem_aluout), 32'hBBBB);

        // HALT
        add_op(16'hC0DE); ex_opcode = 5'b11111; ex_halt = 1'b1;
        step();
        check_eq("halt_valid", 32'(mem_valid), 32'd1);
        check_eq("halt_aluout", 32'(mem_aluout), 32'hC0DE);
        check_eq("halt_sticky", 32'(mem_halt), 32'd1);
        check_eq("halt_ready", 32'(in_ready), 32'd0);
        add_op(16'h7777); flush = 1'b1;
        step();
        check_eq("hflush_valid", 32'(mem_valid), 32'd0);
        check_eq("hflush_halt", 32'(mem_halt), 32'd1);
        add_op(16'h8888);
        step();
        check_eq("hin_valid", 32'(mem_valid), 32'd0);
        check_eq("hin_ready", 32'(in_ready), 32'd0);
        clear_in(); rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_eq("hrst_halt", 32'(mem_halt), 32'd0);
        check_eq("hrst_ready", 32'(in_ready), 32'd1);

        // Taken branch carrying a halt: redirect issues, then halted (no shadow)
        br_op(5'b01100, 16'h0200, 16'h0010, 1'b1, 1'b0, 1'b0); ex_halt = 1'b1;
        step();
        check_eq("bh_redir", 32'(br_redirect), 32'd1);
        check_eq("bh_target", 32'(br_target), 32'h0210);
        check_eq("bh_halt", 32'(mem_halt), 32'd1);
        add_op(16'h9999);
        step();
        check_eq("bh_after_valid", 32'(mem_valid), 32'd0);
        check_eq("bh_after_redir", 32'(br_redirect), 32'd0);
        check_eq("bh_after_ready", 32'(in_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register between the execute-stage ALU and the memory stage of the 16-bit core.
- Captures the ALU result, store data and control bits each cycle.
- Resolves conditional branches (BEQZ/BNEZ/BLTZ/BGEZ, opcodes 011xx) from the ALU zero/sign flags and issues a registered redirect.
- After a taken branch it squashes the younger wrong-path instructions; it also latches HALT and stops the pipe.

Parameters:
- SHADOW_DEPTH, 2: number of accepted younger instructions squashed after a taken branch (1..7).
- WIDTH, 16: datapath width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  EX holds a valid instruction.
- in_ready  out  1  stage can accept this cycle; in_ready = ~stall & ~halted (combinational).
- stall  in  1  MEM stage not ready; all state holds.
- flush  in  1  squash the stage contents.
- ex_opcode  in  5  instruction opcode.
- ex_funct  in  2  instruction funct (passed through to ex_funct_q).
- aluout  in  WIDTH  ALU result.
- equalto  in  1  ALU branch flag: src1 == 0.
- lt  in  1  ALU branch flag: src1 negative.
- gt  in  1  ALU branch flag: src1 non-negative.
- ex_pc_plus2  in  WIDTH  PC+2 of the instruction.
- ex_br_offset  in  WIDTH  sign-extended branch displacement.
- ex_store_data  in  WIDTH  store data.
- ex_wr_reg  in  3  destination register.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_halt  in  1 each  control bits.
- mem_valid  out  1  registered valid.
- mem_aluout, mem_store_data  out  WIDTH  registered.
- mem_wr_reg  out  3  registered.
- mem_reg_write, mem_mem_read, mem_mem_write  out  1  registered; gated by mem_valid.
- ex_funct_q  out  2  registered funct.
- mem_halt  out  1  sticky halt indicator.
- br_redirect  out  1  one-cycle pulse: taken branch.
- br_target  out  WIDTH  redirect PC; valid while br_redirect=1.

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - Reset rst is synchronous, active-high.
  - Reset clears every output to 0, sets state=RUN and shadow_cnt=0.
- Priority: rst > flush > stall > accept.
- Accept:
  - Occurs when in_valid & in_ready & ~flush.
  - Latency 1: the next cycle, mem_* reflect the inputs and mem_valid=1.
  - No accept (and no stall): mem_valid=0, and mem_reg_write/mem_mem_read/mem_mem_write are forced to 0.
- Stall: all registers, state and shadow_cnt hold; br_redirect is forced 0 on the next edge (the pulse never stretches).
- Branch resolution (on accept, only when state=RUN):
  - 01100: taken = equalto.
  - 01101: taken = ~equalto.
  - 01110: taken = lt.
  - 01111: taken = gt.
  - When taken, next cycle: br_redirect=1 and br_target = ex_pc_plus2 + ex_br_offset (mod 2^WIDTH, carry dropped).
  - The branch itself still appears with mem_valid=1 and its control bits as supplied.
- States:
  - RUN:
    - Taken branch accepted -> SHADOW, with shadow_cnt=SHADOW_DEPTH.
    - ex_halt accepted -> HALTED.
  - SHADOW:
    - Each accepted input is dropped: mem_valid=0 next cycle, shadow_cnt decrements.
    - Dropped branches produce no redirect; dropped halts are ignored.
    - When shadow_cnt reaches 0 after a decrement -> RUN.
    - Cycles with in_valid=0 do not decrement.
  - HALTED:
    - mem_halt=1 from the cycle after the halt is accepted; the halt instruction itself is output with mem_valid=1.
    - in_ready=0 and mem_valid=0 after the halt's own cycle.
    - Left only by rst.
- flush:
  - Next cycle: mem_valid=0, br_redirect=0, shadow_cnt=0; SHADOW -> RUN.
  - Does not leave HALTED and does not clear mem_halt.
  - Flush with stall: flush wins.
- Simultaneous taken branch and ex_halt on one accept: the redirect issues and state -> HALTED (halt dominates the shadow).
- Reset mid-shadow or mid-stall: everything returns to reset values on the next edge.
- Non-branch opcodes: never redirect, whatever the flag values.

Test Plan:
- Reset then accept ADD, aluout=0x1234, wr_reg=3, reg_write=1 -> next cycle mem_valid=1, mem_aluout=0x1234, mem_wr_reg=3; in_valid=0 the following cycle -> mem_valid=0, mem_reg_write=0.
- BEQZ, pc_plus2=0x0010, offset=0xFFF8, equalto=1 -> br_redirect=1 for one cycle with br_target=0x0008. Then 3 valid ADDs -> first 2 give mem_valid=0, third gives mem_valid=1.
- BLTZ with lt=0; BGEZ with gt=1, pc_plus2=0xFFFE, offset=0x0004 -> BLTZ: no redirect. BGEZ: br_target=0x0002 (wrap).
- Taken branch accepted with stall=1 on the next cycle -> br_redirect high exactly one cycle; mem_aluout held during the stall; shadow_cnt unchanged during the stall.
- In SHADOW, assert flush -> mem_valid=0 next cycle; the following ADD is accepted with mem_valid=1 (shadow cancelled).
- Accept HALT -> mem_valid=1 for one cycle, then mem_halt=1, in_ready=0. flush and in_valid have no effect; rst clears mem_halt.
